// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the CPU-side sram arbiter: FSM states, grant owner and access sizes.
package cpu_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } arb_gnt_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like port between fetch and load/store masters, one access in flight,
// data side has fixed priority; responses are routed back to the granted master.
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          inst_req_i,
    input  logic          inst_wr_i,
    input  logic [1:0]    inst_size_i,
    input  logic [AW-1:0] inst_addr_i,
    input  logic [DW-1:0] inst_wdata_i,
    output logic          inst_addr_ok_o,
    output logic          inst_data_ok_o,
    output logic [DW-1:0] inst_rdata_o,

    input  logic          data_req_i,
    input  logic          data_wr_i,
    input  logic [1:0]    data_size_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic          data_addr_ok_o,
    output logic          data_data_ok_o,
    output logic [DW-1:0] data_rdata_o,

    output logic          mem_req_o,
    output logic          mem_wr_o,
    output logic [1:0]    mem_size_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_addr_ok_i,
    input  logic          mem_data_ok_i,
    input  logic [DW-1:0] mem_rdata_i
);

    arb_state_e    state_q;
    arb_gnt_e      gnt_q;
    logic          mem_req_q;
    logic          mem_wr_q;
    logic [1:0]    mem_size_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_INST;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= SZ_BYTE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    // Winner's fields are captured once; later changes by the master are ignored.
                    if (data_req_i) begin
                        gnt_q       <= GNT_DATA;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= data_wr_i;
                        mem_size_q  <= data_size_i;
                        mem_addr_q  <= data_addr_i;
                        mem_wdata_q <= data_wdata_i;
                        state_q     <= ARB_REQ;
                    end else if (inst_req_i) begin
                        gnt_q       <= GNT_INST;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= inst_wr_i;
                        mem_size_q  <= inst_size_i;
                        mem_addr_q  <= inst_addr_i;
                        mem_wdata_q <= inst_wdata_i;
                        state_q     <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_addr_ok_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_data_ok_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    logic in_req;
    logic in_resp;
    assign in_req  = (state_q == ARB_REQ);
    assign in_resp = (state_q == ARB_RESP);

    assign inst_addr_ok_o = in_req  && mem_addr_ok_i && (gnt_q == GNT_INST);
    assign data_addr_ok_o = in_req  && mem_addr_ok_i && (gnt_q == GNT_DATA);
    assign inst_data_ok_o = in_resp && mem_data_ok_i && (gnt_q == GNT_INST);
    assign data_data_ok_o = in_resp && mem_data_ok_i && (gnt_q == GNT_DATA);
    assign inst_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign mem_req_o   = mem_req_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_size_o  = mem_size_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Randomized bench for cpu_sram_arbiter: master/slave drivers plus a transaction-level
// reference model and scoreboard sampled on the falling edge.
module tb_cpu_sram_arbiter;
    import cpu_sram_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req_i, inst_wr_i, data_req_i, data_wr_i;
    logic [1:0]    inst_size_i, data_size_i;
    logic [AW-1:0] inst_addr_i, data_addr_i;
    logic [DW-1:0] inst_wdata_i, data_wdata_i;
    logic          inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o;
    logic [DW-1:0] inst_rdata_o, data_rdata_o;
    logic          mem_req_o, mem_wr_o;
    logic [1:0]    mem_size_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_addr_ok_i, mem_data_ok_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_req_i     (inst_req_i),
        .inst_wr_i      (inst_wr_i),
        .inst_size_i    (inst_size_i),
        .inst_addr_i    (inst_addr_i),
        .inst_wdata_i   (inst_wdata_i),
        .inst_addr_ok_o (inst_addr_ok_o),
        .inst_data_ok_o (inst_data_ok_o),
        .inst_rdata_o   (inst_rdata_o),
        .data_req_i     (data_req_i),
        .data_wr_i      (data_wr_i),
        .data_size_i    (data_size_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_addr_ok_o (data_addr_ok_o),
        .data_data_ok_o (data_data_ok_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_wr_o       (mem_wr_o),
        .mem_size_o     (mem_size_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_addr_ok_i  (mem_addr_ok_i),
        .mem_data_ok_i  (mem_data_ok_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    txn_t inst_feed[$], data_feed[$];     // stimulus waiting to be issued
    txn_t inst_exp_q[$], data_exp_q[$];   // issued, awaiting acceptance at the slave
    int   resp_q[$];                      // accepted, awaiting response: 0=inst 1=data
    int   dok_times[$];                   // cycles of observed data_data_ok pulses
    int   aok_log[$];                     // observed acceptance order: 0=inst 1=data
    int   last_req_run = 0;
    logic inst_busy = 1'b0, data_busy = 1'b0;
    logic fast = 1'b0, mute = 1'b0, force_dok = 1'b0;
    int   bp_len = 0, bp_token = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] d, int gap);
        txn_t t;
        t.wr = wr; t.size = sz; t.addr = a; t.wdata = d; t.gap = gap;
        return t;
    endfunction

    initial begin : inst_master
        txn_t t;
        int   n;
        inst_req_i = 0; inst_wr_i = 0; inst_size_i = 0; inst_addr_i = 0; inst_wdata_i = 0;
        forever begin
            if (inst_feed.size() == 0) begin
                @(posedge clk); #1;
            end else begin
                inst_busy = 1'b1;
                t = inst_feed.pop_front();
                repeat (t.gap) begin @(posedge clk); #1; end
                inst_req_i = 1; inst_wr_i = t.wr; inst_size_i = t.size;
                inst_addr_i = t.addr; inst_wdata_i = t.wdata;
                inst_exp_q.push_back(t);
                n = 0;
                do begin @(negedge clk); n++; end while (!inst_addr_ok_o && n < 5000);
                chk("inst_accept_wait", inst_addr_ok_o, 1);
                @(posedge clk); #1;
                inst_req_i = 0; inst_wr_i = 1'($urandom); inst_size_i = 2'($urandom);
                inst_addr_i = $urandom; inst_wdata_i = $urandom;
                inst_busy = 1'b0;
            end
        end
    end

    initial begin : data_master
        txn_t t;
        int   n;
        data_req_i = 0; data_wr_i = 0; data_size_i = 0; data_addr_i = 0; data_wdata_i = 0;
        forever begin
            if (data_feed.size() == 0) begin
                @(posedge clk); #1;
            end else begin
                data_busy = 1'b1;
                t = data_feed.pop_front();
                repeat (t.gap) begin @(posedge clk); #1; end
                data_req_i = 1; data_wr_i = t.wr; data_size_i = t.size;
                data_addr_i = t.addr; data_wdata_i = t.wdata;
                data_exp_q.push_back(t);
                n = 0;
                do begin @(negedge clk); n++; end while (!data_addr_ok_o && n < 5000);
                chk("data_accept_wait", data_addr_ok_o, 1);
                @(posedge clk); #1;
                data_req_i = 0; data_wr_i = 1'($urandom); data_size_i = 2'($urandom);
                data_addr_i = $urandom; data_wdata_i = $urandom;
                data_busy = 1'b0;
            end
        end
    end

    // Slave: random acceptance/response; stray data_ok is allowed at any time.
    initial begin : slave
        int bp_left = 0;
        int seen = 0;
        mem_addr_ok_i = 0; mem_data_ok_i = 0; mem_rdata_i = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_token != seen) begin seen = bp_token; bp_left = bp_len; end
            mem_rdata_i = $urandom;
            if (mem_req_o && bp_left > 0) begin
                mem_addr_ok_i = 0;
                bp_left--;
            end else if (fast) begin
                mem_addr_ok_i = mem_req_o;
            end else begin
                mem_addr_ok_i = mem_req_o && ($urandom_range(2) != 0);
            end
            mem_data_ok_i = (force_dok || fast) ? 1'b1 : mute ? 1'b0 : ($urandom_range(2) == 0);
        end
    end

    // Reference model: an idle arbiter grants the data master if it was requesting, else the
    // fetch master; the request is held until accepted, then exactly one response follows.
    initial begin : monitor
        int   cyc = 0, run = 0, cur_who = 0;
        logic prev_free = 1, prev_inst = 0, prev_data = 0, prev_mreq = 0, prev_hs = 0;
        logic expect_zero = 0, exp_dok, exp_mreq, hs, had_resp, grant;
        txn_t t;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                resp_q.delete();
                prev_free = 1; prev_inst = 0; prev_data = 0; prev_mreq = 0; prev_hs = 0;
                expect_zero = 1; run = 0;
            end else begin
                if (expect_zero) begin
                    chk("rst_mem_req", mem_req_o, 0);
                    chk("rst_mem_wr", mem_wr_o, 0);
                    chk("rst_mem_size", mem_size_o, 0);
                    chk("rst_mem_addr", mem_addr_o, 0);
                    chk("rst_mem_wdata", mem_wdata_o, 0);
                    chk("rst_oks", {inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o}, 0);
                    expect_zero = 0;
                end
                had_resp = (resp_q.size() != 0);
                exp_dok  = had_resp && mem_data_ok_i;
                chk("inst_data_ok", inst_data_ok_o, exp_dok && resp_q[0] == 0);
                chk("data_data_ok", data_data_ok_o, exp_dok && resp_q[0] == 1);
                chk("inst_rdata", inst_rdata_o, mem_rdata_i);
                chk("data_rdata", data_rdata_o, mem_rdata_i);
                if (data_data_ok_o) dok_times.push_back(cyc);
                if (exp_dok) void'(resp_q.pop_front());

                grant    = prev_free && (prev_inst || prev_data);
                exp_mreq = grant || (prev_mreq && !prev_hs);
                if (grant) cur_who = prev_data ? 1 : 0;
                chk("mem_req", mem_req_o, exp_mreq);
                hs = exp_mreq && mem_addr_ok_i;
                if (exp_mreq) begin
                    if ((cur_who == 1 ? data_exp_q.size() : inst_exp_q.size()) == 0) begin
                        chk("granted_master_has_request", 0, 1);
                    end else begin
                        t = (cur_who == 1) ? data_exp_q[0] : inst_exp_q[0];
                        chk("mem_wr", mem_wr_o, t.wr);
                        chk("mem_size", mem_size_o, t.size);
                        chk("mem_addr", mem_addr_o, t.addr);
                        chk("mem_wdata", mem_wdata_o, t.wdata);
                    end
                end
                chk("inst_addr_ok", inst_addr_ok_o, hs && cur_who == 0);
                chk("data_addr_ok", data_addr_ok_o, hs && cur_who == 1);
                if (inst_addr_ok_o || data_addr_ok_o) aok_log.push_back(data_addr_ok_o ? 1 : 0);
                if (hs) begin
                    if (cur_who == 1 && data_exp_q.size() != 0) void'(data_exp_q.pop_front());
                    if (cur_who == 0 && inst_exp_q.size() != 0) void'(inst_exp_q.pop_front());
                    resp_q.push_back(cur_who);
                end

                if (mem_req_o) run++;
                else if (run != 0) begin last_req_run = run; run = 0; end

                prev_free = !exp_mreq && !had_resp;
                prev_inst = inst_req_i; prev_data = data_req_i;
                prev_mreq = exp_mreq;   prev_hs   = hs;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(inst_feed.size() == 0 && data_feed.size() == 0 && !inst_busy &&
               !data_busy && resp_q.size() == 0 && !mem_req_o)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: still busy after %0d cycles, want idle", budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Single fetch with an immediate slave.
        fast = 1;
        inst_feed.push_back(mk(0, SZ_WORD, 32'hbfc00000, 32'h0, 1));
        wait_idle(200);
        chk("fetch_req_cycles", last_req_run, 1);
        fast = 0;

        // Simultaneous requests: data must be accepted first.
        aok_log.delete();
        data_feed.push_back(mk(1, SZ_WORD, 32'h80000010, 32'hdeadbeef, 0));
        inst_feed.push_back(mk(0, SZ_WORD, 32'hbfc00004, 32'h0, 0));
        wait_idle(400);
        chk("simul_accepts", aok_log.size(), 2);
        if (aok_log.size() == 2) begin
            chk("simul_first_is_data", aok_log[0], 1);
            chk("simul_second_is_inst", aok_log[1], 0);
        end

        // Back-pressure for 5 cycles, with stray data_ok in IDLE and REQ throughout.
        fast = 1; force_dok = 1; bp_len = 5; bp_token++;
        repeat (3) @(posedge clk);
        #1;
        inst_feed.push_back(mk(0, SZ_HALF, 32'hbfc00008, 32'h0, 2));
        wait_idle(200);
        chk("backpressure_req_cycles", last_req_run, 6);
        fast = 0; force_dok = 0;

        // Reset while waiting for the response; a late data_ok must be dropped.
        mute = 1;
        inst_feed.push_back(mk(0, SZ_WORD, 32'hbfc00100, 32'h0, 0));
        n = 0;
        while (resp_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_setup: no acceptance within 200 cycles, want one");
        end
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0; force_dok = 1;
        @(posedge clk); #1 force_dok = 0; mute = 0;
        inst_feed.push_back(mk(0, SZ_WORD, 32'hbfc00104, 32'h0, 1));
        wait_idle(400);

        // Back-to-back loads: responses 3 cycles apart.
        fast = 1;
        dok_times.delete();
        for (int i = 0; i < 4; i++) data_feed.push_back(mk(0, SZ_WORD, 32'(i * 4), 32'h0, 0));
        wait_idle(200);
        chk("b2b_responses", dok_times.size(), 4);
        for (int i = 1; i < dok_times.size(); i++) chk("b2b_spacing", dok_times[i] - dok_times[i-1], 3);
        fast = 0;

        // Randomized traffic from both masters.
        for (int i = 0; i < 40; i++) begin
            inst_feed.push_back(mk(1'($urandom_range(7) == 0), 2'($urandom_range(2)), $urandom,
                                   $urandom, $urandom_range(4)));
            data_feed.push_back(mk(1'($urandom), 2'($urandom_range(2)), $urandom, $urandom,
                                   $urandom_range(5)));
        end
        wait_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
